// File: rtl/serial_adder_subtractor_pkg.sv
// Shared types and constants for the digit-serial add/subtract unit.
package serial_adder_subtractor_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic {
        STATE_IDLE = 1'b0,
        STATE_RUN  = 1'b1
    } state_e;

    function automatic int steps_of(input int bits, input int digit);
        return bits / digit;
    endfunction

    function automatic int cnt_width(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_subtractor_digit_adder.sv
// DIGIT-bit adder slice; exposes the carry into its top bit for overflow.
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             carry_in,
    output logic [DIGIT-1:0] sum,
    output logic             carry_out,
    output logic             msb_carry_in
);

    logic [DIGIT:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, carry_in};
    assign sum = full[DIGIT-1:0];
    assign carry_out = full[DIGIT];
    assign msb_carry_in = sum[DIGIT-1] ^ a[DIGIT-1] ^ b[DIGIT-1];

endmodule

// File: rtl/serial_adder_subtractor.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, LSD first,
// with start/busy/done handshake and carry/borrow and overflow flags.
module serial_adder_subtractor
    import serial_adder_subtractor_pkg::*;
#(
    parameter int BITS  = 16,
    parameter int DIGIT = 4
) (
    input  logic            i_clock,
    input  logic            i_reset_n,
    input  logic            i_start,
    input  logic            i_mode,
    input  logic [BITS-1:0] i_operand_a,
    input  logic [BITS-1:0] i_operand_b,
    output logic            o_busy,
    output logic            o_done,
    output logic [BITS-1:0] o_result,
    output logic            o_carry,
    output logic            o_overflow
);

    localparam int STEPS = steps_of(BITS, DIGIT);
    localparam int CW = cnt_width(STEPS);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    if (DIGIT < 1 || DIGIT > BITS || (BITS % DIGIT) != 0) begin : g_param_check
        $error("BITS must be a positive multiple of DIGIT");
    end

    state_e          state_q;
    logic [BITS-1:0] a_q;
    logic [BITS-1:0] b_q;
    logic [BITS-1:0] acc_q;
    logic [BITS-1:0] acc_d;
    logic [BITS-1:0] result_q;
    logic [CW-1:0]   cnt_q;
    logic            mode_q;
    logic            carry_q;
    logic            done_q;
    logic            cout_q;
    logic            ovf_q;

    logic [DIGIT-1:0] slice_sum;
    logic             slice_co;
    logic             slice_msb_ci;

    digit_adder #(
        .DIGIT(DIGIT)
    ) u_slice (
        .a           (a_q[DIGIT-1:0]),
        .b           (b_q[DIGIT-1:0]),
        .carry_in    (carry_q),
        .sum         (slice_sum),
        .carry_out   (slice_co),
        .msb_carry_in(slice_msb_ci)
    );

    // New digit enters at the top so the LSD ends up at bit 0.
    assign acc_d = (acc_q >> DIGIT) | (BITS'(slice_sum) << (BITS - DIGIT));

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= STATE_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                STATE_IDLE: begin
                    if (i_start) begin
                        a_q     <= i_operand_a;
                        b_q     <= (i_mode == MODE_SUB) ? ~i_operand_b : i_operand_b;
                        mode_q  <= i_mode;
                        carry_q <= (i_mode == MODE_SUB);
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        state_q <= STATE_RUN;
                    end
                end
                STATE_RUN: begin
                    acc_q   <= acc_d;
                    carry_q <= slice_co;
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        result_q <= acc_d;
                        cout_q   <= (mode_q == MODE_ADD) ? slice_co : ~slice_co;
                        ovf_q    <= slice_msb_ci ^ slice_co;
                        done_q   <= 1'b1;
                        state_q  <= STATE_IDLE;
                    end
                end
                default: state_q <= STATE_IDLE;
            endcase
        end
    end

    assign o_busy     = (state_q == STATE_RUN);
    assign o_done     = done_q;
    assign o_result   = result_q;
    assign o_carry    = cout_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_subtractor.sv
// Directed bench for serial_adder_subtractor over four parameter sets.
module tb_serial_adder_subtractor;

    logic clk;
    logic rst_n;

    logic        s1_start, s1_mode, s1_busy, s1_done, s1_c, s1_o;
    logic [3:0]  s1_a, s1_b, s1_r;
    logic        s2_start, s2_mode, s2_busy, s2_done, s2_c, s2_o;
    logic [3:0]  s2_a, s2_b, s2_r;
    logic        s3_start, s3_mode, s3_busy, s3_done, s3_c, s3_o;
    logic [15:0] s3_a, s3_b, s3_r;
    logic        s4_start, s4_mode, s4_busy, s4_done, s4_c, s4_o;
    logic [7:0]  s4_a, s4_b, s4_r;

    int checks = 0;
    int passed = 0;

    serial_adder_subtractor #(.BITS(4), .DIGIT(1)) u_d1 (
        .i_clock(clk), .i_reset_n(rst_n), .i_start(s1_start), .i_mode(s1_mode),
        .i_operand_a(s1_a), .i_operand_b(s1_b), .o_busy(s1_busy), .o_done(s1_done),
        .o_result(s1_r), .o_carry(s1_c), .o_overflow(s1_o)
    );

    serial_adder_subtractor #(.BITS(4), .DIGIT(2)) u_d2 (
        .i_clock(clk), .i_reset_n(rst_n), .i_start(s2_start), .i_mode(s2_mode),
        .i_operand_a(s2_a), .i_operand_b(s2_b), .o_busy(s2_busy), .o_done(s2_done),
        .o_result(s2_r), .o_carry(s2_c), .o_overflow(s2_o)
    );

    serial_adder_subtractor #(.BITS(16), .DIGIT(4)) u_d3 (
        .i_clock(clk), .i_reset_n(rst_n), .i_start(s3_start), .i_mode(s3_mode),
        .i_operand_a(s3_a), .i_operand_b(s3_b), .o_busy(s3_busy), .o_done(s3_done),
        .o_result(s3_r), .o_carry(s3_c), .o_overflow(s3_o)
    );

    serial_adder_subtractor #(.BITS(8), .DIGIT(8)) u_d4 (
        .i_clock(clk), .i_reset_n(rst_n), .i_start(s4_start), .i_mode(s4_mode),
        .i_operand_a(s4_a), .i_operand_b(s4_b), .o_busy(s4_busy), .o_done(s4_done),
        .o_result(s4_r), .o_carry(s4_c), .o_overflow(s4_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        {s1_start, s1_mode, s1_a, s1_b} = '0;
        {s2_start, s2_mode, s2_a, s2_b} = '0;
        {s3_start, s3_mode, s3_a, s3_b} = '0;
        {s4_start, s4_mode, s4_a, s4_b} = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({s1_busy, s1_done, s1_r, s1_c, s1_o, s2_busy, s2_done, s2_r, s2_c, s2_o} !== '0)
            $display("FAIL reset_small: got %b want 0",
                     {s1_busy, s1_done, s1_r, s1_c, s1_o, s2_busy, s2_done, s2_r, s2_c, s2_o});
        else passed++;
        checks++;
        if ({s3_busy, s3_done, s3_r, s3_c, s3_o, s4_busy, s4_done, s4_r, s4_c, s4_o} !== '0)
            $display("FAIL reset_wide: got %b want 0",
                     {s3_busy, s3_done, s3_r, s3_c, s3_o, s4_busy, s4_done, s4_r, s4_c, s4_o});
        else passed++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_exhaustive();
        int cyc;
        logic [4:0] full;
        logic [3:0] er;
        logic ec, eo;
        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    s1_mode = m[0];
                    s1_a = a[3:0];
                    s1_b = b[3:0];
                    s1_start = 1'b1;
                    @(posedge clk);
                    #1;
                    s1_start = 1'b0;
                    cyc = 0;
                    while (!s1_done && cyc < 10) begin
                        @(posedge clk);
                        #1;
                        cyc++;
                    end
                    if (m == 0) begin
                        full = {1'b0, a[3:0]} + {1'b0, b[3:0]};
                        er = full[3:0];
                        ec = full[4];
                        eo = (a[3] == b[3]) && (er[3] != a[3]);
                    end else begin
                        er = a[3:0] - b[3:0];
                        ec = (a < b);
                        eo = (a[3] != b[3]) && (er[3] != a[3]);
                    end
                    checks++;
                    if ({s1_r, s1_c, s1_o} !== {er, ec, eo})
                        $display("FAIL exh m=%0d a=%0d b=%0d: got r=%0d c=%b o=%b want r=%0d c=%b o=%b",
                                 m, a, b, s1_r, s1_c, s1_o, er, ec, eo);
                    else passed++;
                    checks++;
                    if (cyc !== 4 || s1_busy !== 1'b0)
                        $display("FAIL exh_latency m=%0d a=%0d b=%0d: got %0d busy=%b want 4 busy=0",
                                 m, a, b, cyc, s1_busy);
                    else passed++;
                end
            end
        end
    endtask

    task automatic test_digit2();
        logic [14:0] vec [4];
        int cyc;
        // {mode, a, b, result, carry, overflow}
        vec[0] = {1'b1, 4'd3,  4'd5, 4'd14, 1'b1, 1'b0};
        vec[1] = {1'b0, 4'd7,  4'd1, 4'd8,  1'b0, 1'b1};
        vec[2] = {1'b0, 4'd15, 4'd1, 4'd0,  1'b1, 1'b0};
        vec[3] = {1'b1, 4'd8,  4'd1, 4'd7,  1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            s2_mode = vec[i][14];
            s2_a = vec[i][13:10];
            s2_b = vec[i][9:6];
            s2_start = 1'b1;
            @(posedge clk);
            #1;
            s2_start = 1'b0;
            cyc = 0;
            while (!s2_done && cyc < 10) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            checks++;
            if ({s2_r, s2_c, s2_o} !== vec[i][5:0] || cyc !== 2)
                $display("FAIL digit2_%0d: got r=%0d c=%b o=%b lat=%0d want r=%0d c=%b o=%b lat=2",
                         i, s2_r, s2_c, s2_o, cyc, vec[i][5:2], vec[i][1], vec[i][0]);
            else passed++;
        end
    endtask

    task automatic test_full_digit();
        s4_mode = 1'b1;
        s4_a = 8'h00;
        s4_b = 8'h01;
        s4_start = 1'b1;
        @(posedge clk);
        #1;
        s4_start = 1'b0;
        checks++;
        if ({s4_busy, s4_done} !== 2'b10)
            $display("FAIL full_digit_busy: got busy=%b done=%b want busy=1 done=0", s4_busy, s4_done);
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if ({s4_busy, s4_done, s4_r, s4_c, s4_o} !== {2'b01, 8'hFF, 1'b1, 1'b0})
            $display("FAIL full_digit: got busy=%b done=%b r=%h c=%b o=%b want 0 1 ff 1 0",
                     s4_busy, s4_done, s4_r, s4_c, s4_o);
        else passed++;
    endtask

    task automatic test_ignore_start();
        int cyc;
        s3_mode = 1'b0;
        s3_a = 16'h1234;
        s3_b = 16'h0FFF;
        s3_start = 1'b1;
        @(posedge clk);
        #1;
        s3_start = 1'b0;
        cyc = 0;
        @(posedge clk);
        #1;
        cyc++;
        s3_mode = 1'b1;
        s3_a = 16'hFFFF;
        s3_b = 16'h0001;
        s3_start = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        s3_start = 1'b0;
        while (!s3_done && cyc < 10) begin
            checks++;
            if (s3_busy !== 1'b1)
                $display("FAIL ignore_busy: got %b want 1 at cycle %0d", s3_busy, cyc);
            else passed++;
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if ({s3_r, s3_c, s3_o} !== {16'h2233, 1'b0, 1'b0} || cyc !== 4)
            $display("FAIL ignore_start: got r=%h c=%b o=%b lat=%0d want r=2233 c=0 o=0 lat=4",
                     s3_r, s3_c, s3_o, cyc);
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if ({s3_busy, s3_done} !== 2'b00)
            $display("FAIL ignore_idle: got busy=%b done=%b want 0 0", s3_busy, s3_done);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int cyc;
        int busy_cnt;
        s3_mode = 1'b0;
        s3_a = 16'h1234;
        s3_b = 16'h0FFF;
        s3_start = 1'b1;
        @(posedge clk);
        #1;
        s3_mode = 1'b1;
        s3_a = 16'h8000;
        s3_b = 16'h0001;
        cyc = 0;
        while (!s3_done && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if ({s3_busy, s3_done, s3_r, s3_c, s3_o} !== {2'b01, 16'h2233, 1'b0, 1'b0} || cyc !== 4)
            $display("FAIL b2b_first: got busy=%b done=%b r=%h c=%b lat=%0d want 0 1 2233 0 lat=4",
                     s3_busy, s3_done, s3_r, s3_c, cyc);
        else passed++;
        @(posedge clk);
        #1;
        s3_start = 1'b0;
        busy_cnt = 0;
        cyc = 0;
        while (!s3_done && cyc < 10) begin
            if (s3_busy) busy_cnt++;
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (busy_cnt !== 4 || s3_busy !== 1'b0)
            $display("FAIL b2b_busy: got %0d busy cycles want 4", busy_cnt);
        else passed++;
        checks++;
        if ({s3_r, s3_c, s3_o} !== {16'h7FFF, 1'b0, 1'b1})
            $display("FAIL b2b_second: got r=%h c=%b o=%b want r=7fff c=0 o=1", s3_r, s3_c, s3_o);
        else passed++;
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        logic seen_done;
        s3_mode = 1'b0;
        s3_a = 16'h1234;
        s3_b = 16'h0FFF;
        s3_start = 1'b1;
        @(posedge clk);
        #1;
        s3_start = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s3_busy, s3_done, s3_r, s3_c, s3_o} !== '0)
            $display("FAIL midrun_reset: got busy=%b done=%b r=%h c=%b o=%b want all 0",
                     s3_busy, s3_done, s3_r, s3_c, s3_o);
        else passed++;
        seen_done = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (s3_done) seen_done = 1'b1;
        end
        #3;
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (s3_done || s3_busy) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0)
            $display("FAIL midrun_no_done: got activity=%b want 0", seen_done);
        else passed++;
        s3_a = 16'h7FFF;
        s3_b = 16'h0001;
        s3_start = 1'b1;
        @(posedge clk);
        #1;
        s3_start = 1'b0;
        cyc = 0;
        while (!s3_done && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if ({s3_r, s3_c, s3_o} !== {16'h8000, 1'b0, 1'b1} || cyc !== 4)
            $display("FAIL midrun_after: got r=%h c=%b o=%b lat=%0d want r=8000 c=0 o=1 lat=4",
                     s3_r, s3_c, s3_o, cyc);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_exhaustive();
        test_digit2();
        test_full_digit();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/serial_adder_subtractor.md
# serial_adder_subtractor

Digit-serial add/subtract unit: a sequential, parametrised successor to the combinational subtractor. It accepts two BITS-wide operands and a mode, then processes DIGIT bits per clock, least-significant digit first. It reports the result, an unsigned carry/borrow flag and a signed overflow flag through a start/busy/done handshake. It serves datapaths that trade latency for adder area, or that share one narrow adder slice across wide operands.

## Interface
- BITS, 16, operand/result width; must be a multiple of DIGIT
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ BITS; STEPS = BITS / DIGIT
- i_clock  input  1  rising-edge clock
- i_reset_n  input  1  reset, asynchronous and active-low
- i_start  input  1  request; sampled only while idle
- i_mode  input  1  0 = add (A + B), 1 = subtract (A − B)
- i_operand_a  input  BITS  first operand (minuend for subtract)
- i_operand_b  input  BITS  second operand (subtrahend for subtract)
- o_busy  output  1  operation in progress
- o_done  output  1  one-cycle pulse: results just updated
- o_result  output  BITS  sum or difference, modulo 2^BITS
- o_carry  output  1  add: unsigned carry-out; subtract: unsigned borrow (A < B)
- o_overflow  output  1  two's-complement overflow of the operation

## Operation
- States: IDLE, RUN.
- **IDLE + i_start=1:**
  - latch A, B (inverted when i_mode=1) and mode into shift registers;
  - carry register ← i_mode (subtract = A + ~B + 1);
  - step counter ← 0; go to RUN.
- **IDLE + i_start=0:** hold all state and outputs.
- **RUN, each cycle:**
  - the slice adds the low DIGIT bits of both shift registers plus the carry register;
  - the sum digit shifts into the result register from the MSB end;
  - carry register ← slice carry-out;
  - operand registers shift right by DIGIT.
- **RUN, final step (counter = STEPS−1):**
  - o_result ← completed result;
  - o_carry ← carry-out for add, inverted carry-out for subtract;
  - o_overflow ← carry into MSB XOR carry out of MSB (from the slice);
  - o_done ← 1; go to IDLE.
- i_start is ignored during RUN; the operands and mode are not re-sampled.
- Outside o_done updates, o_result, o_carry and o_overflow hold their last values.
- Width rule: the slice is DIGIT+1 bits wide internally. No sign extension is needed; overflow comes only from the final digit.

## Timing
- Reset (asynchronous assert, any state): state IDLE; o_busy=0; o_done=0; o_result=0; o_carry=0; o_overflow=0; internal registers 0.
- Reset mid-RUN aborts the operation: no o_done, outputs return to 0.
- Start accepted at edge E. o_busy=1 during cycles E+1 … E+STEPS.
- At edge E+STEPS: o_busy→0; o_done→1 for exactly one cycle; results valid from that edge.
- Latency: STEPS cycles from the accepting edge to o_done. Throughput: one operation per STEPS cycles.
- i_start held high in the o_done cycle is accepted at the next edge (back-to-back, no gap cycle).
- DIGIT = BITS: STEPS = 1, o_busy high for one cycle, o_done one edge after start.
- o_done and o_busy are never high together.

## Structure
- Shared package holds:
  - mode constants MODE_ADD = 1'b0 and MODE_SUB = 1'b1;
  - state encoding STATE_IDLE / STATE_RUN;
  - the STEPS derivation and a width function for the step counter: clog2(STEPS), minimum 1.
- One sub-module: digit_adder — combinational, parameter DIGIT; inputs a, b, carry_in; outputs sum, carry_out and msb_carry_in (for overflow).
- Top level contains the FSM, counter, shift registers and output registers.
- Parameter check: elaboration error if BITS % DIGIT ≠ 0.

## Test plan
- BITS=4, DIGIT=1, exhaustive over A, B and both modes, checked against a reference model of {carry, result} and signed overflow. Zero mismatches; o_done exactly 4 cycles after each start.
- BITS=4, DIGIT=2, subtract 3 − 5 → o_result=14, o_carry=1, o_overflow=0.
- BITS=4, DIGIT=2, add cases:
  - 7 + 1 → o_result=8, o_carry=0, o_overflow=1;
  - 15 + 1 → o_result=0, o_carry=1, o_overflow=0.
- BITS=4, DIGIT=2, subtract 8 − 1 → o_result=7, o_carry=0, o_overflow=1.
- BITS=16, DIGIT=4, add 0x1234 + 0x0FFF:
  - i_start pulsed again during busy with other operands → ignored; o_result=0x2233, o_carry=0;
  - i_start held through the o_done cycle → second operation starts immediately, o_busy high for exactly 4 cycles.
- Reset cases:
  - i_reset_n dropped mid-RUN, asynchronously between edges → all outputs 0 immediately, no o_done; a new start after release completes normally.
  - DIGIT=BITS=8, subtract 0x00 − 0x01 → o_result=0xFF, o_carry=1, o_done one edge after start.
